// File: rtl/arp_tx_gen_if.sv
// Byte-stream handshake between the ARP frame generator and the MAC-layer arbiter.
interface arp_tx_gen_if;
    logic [7:0] mac_data;
    logic       mac_valid;
    logic       mac_last;
    logic       mac_ready;

    modport master (
        output mac_data,
        output mac_valid,
        output mac_last,
        input  mac_ready
    );

    modport slave (
        input  mac_data,
        input  mac_valid,
        input  mac_last,
        output mac_ready
    );
endinterface

// File: rtl/arp_tx_gen.sv
// ARP request/reply frame generator: queues triggers, snapshots fields, streams padded payload bytes.
module arp_tx_gen #(
    parameter logic [31:0] P_DST_IP       = 32'hC0A8_0A00,
    parameter logic [31:0] P_SRC_IP       = 32'hC0A8_0A01,
    parameter logic [47:0] P_SRC_MAC      = 48'h0,
    parameter logic [47:0] P_REQ_THA      = 48'hFFFF_FFFF_FFFF,
    parameter int unsigned P_FRAME_LEN    = 46,
    parameter int unsigned P_RETRY_CYCLES = 125_000_000,
    parameter int unsigned P_RETRY_MAX    = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [31:0]         i_dst_ip,
    input  logic                i_dst_ip_valid,
    input  logic [31:0]         i_src_ip,
    input  logic                i_src_ip_valid,
    input  logic [47:0]         i_src_mac,
    input  logic                i_src_mac_valid,
    input  logic                i_trig_reply,
    input  logic [47:0]         i_reply_mac,
    input  logic [31:0]         i_reply_ip,
    input  logic                i_active_req,
    input  logic                i_resolved,
    arp_tx_gen_if.master        mac,
    output logic                o_busy,
    output logic                o_req_fail
);

    localparam int unsigned CNT_W     = 11;
    localparam int unsigned HDR_LEN   = 28;
    localparam int unsigned HDR_IDX_W = 5;
    localparam int unsigned TMR_W     = $clog2(P_RETRY_CYCLES + 1);
    localparam int unsigned RTY_W     = $clog2(P_RETRY_MAX + 2);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(P_FRAME_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(P_RETRY_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(P_RETRY_MAX);
    localparam bit               RETRY_EN = (P_RETRY_MAX != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        dst_ip_q, dst_ip_d;
    logic [31:0]        src_ip_q, src_ip_d;
    logic [47:0]        src_mac_q, src_mac_d;

    logic               reply_pend_q, reply_pend_d;
    logic               req_pend_q, req_pend_d;
    logic [47:0]        reply_mac_q, reply_mac_d;
    logic [31:0]        reply_ip_q, reply_ip_d;

    logic               frm_req_q, frm_req_d;
    logic [47:0]        frm_sha_q, frm_sha_d;
    logic [31:0]        frm_spa_q, frm_spa_d;
    logic [47:0]        frm_tha_q, frm_tha_d;
    logic [31:0]        frm_tpa_q, frm_tpa_d;

    logic               tmr_arm_q, tmr_arm_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [RTY_W-1:0]   retry_cnt_q, retry_cnt_d;

    logic [7:0]         mac_data_q, mac_data_d;
    logic               mac_valid_q, mac_valid_d;
    logic               mac_last_q, mac_last_d;
    logic               busy_q, busy_d;
    logic               req_fail_q, req_fail_d;

    logic               load_reply_c;
    logic               load_req_c;
    logic               frame_done_c;
    logic               retry_set_c;
    logic [HDR_LEN-1:0][7:0] hdr_c;
    logic [HDR_IDX_W-1:0]    hdr_idx_c;

    // State register and all datapath flops, synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            dst_ip_q     <= P_DST_IP;
            src_ip_q     <= P_SRC_IP;
            src_mac_q    <= P_SRC_MAC;
            reply_pend_q <= 1'b0;
            req_pend_q   <= 1'b0;
            reply_mac_q  <= '0;
            reply_ip_q   <= '0;
            frm_req_q    <= 1'b0;
            frm_sha_q    <= '0;
            frm_spa_q    <= '0;
            frm_tha_q    <= '0;
            frm_tpa_q    <= '0;
            tmr_arm_q    <= 1'b0;
            tmr_q        <= '0;
            retry_cnt_q  <= '0;
            mac_data_q   <= '0;
            mac_valid_q  <= 1'b0;
            mac_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            req_fail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dst_ip_q     <= dst_ip_d;
            src_ip_q     <= src_ip_d;
            src_mac_q    <= src_mac_d;
            reply_pend_q <= reply_pend_d;
            req_pend_q   <= req_pend_d;
            reply_mac_q  <= reply_mac_d;
            reply_ip_q   <= reply_ip_d;
            frm_req_q    <= frm_req_d;
            frm_sha_q    <= frm_sha_d;
            frm_spa_q    <= frm_spa_d;
            frm_tha_q    <= frm_tha_d;
            frm_tpa_q    <= frm_tpa_d;
            tmr_arm_q    <= tmr_arm_d;
            tmr_q        <= tmr_d;
            retry_cnt_q  <= retry_cnt_d;
            mac_data_q   <= mac_data_d;
            mac_valid_q  <= mac_valid_d;
            mac_last_q   <= mac_last_d;
            busy_q       <= busy_d;
            req_fail_q   <= req_fail_d;
        end
    end

    // Frame FSM: pick a pending trigger (reply first), snapshot its fields, count bytes out.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        frm_req_d    = frm_req_q;
        frm_sha_d    = frm_sha_q;
        frm_spa_d    = frm_spa_q;
        frm_tha_d    = frm_tha_q;
        frm_tpa_d    = frm_tpa_q;
        load_reply_c = 1'b0;
        load_req_c   = 1'b0;
        frame_done_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (reply_pend_q || req_pend_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d     = '0;
                state_d   = ST_SEND;
                frm_sha_d = src_mac_q;
                frm_spa_d = src_ip_q;
                if (reply_pend_q) begin
                    load_reply_c = 1'b1;
                    frm_req_d    = 1'b0;
                    frm_tha_d    = reply_mac_q;
                    frm_tpa_d    = reply_ip_q;
                end else begin
                    load_req_c   = 1'b1;
                    frm_req_d    = 1'b1;
                    frm_tha_d    = P_REQ_THA;
                    frm_tpa_d    = dst_ip_q;
                end
            end
            ST_SEND: begin
                if (mac.mac_ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d      = ST_IDLE;
                        frame_done_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Configuration registers and pending trigger flags; a new trigger beats a same-cycle clear.
    always_comb begin
        dst_ip_d     = i_dst_ip_valid  ? i_dst_ip  : dst_ip_q;
        src_ip_d     = i_src_ip_valid  ? i_src_ip  : src_ip_q;
        src_mac_d    = i_src_mac_valid ? i_src_mac : src_mac_q;
        reply_pend_d = reply_pend_q;
        reply_mac_d  = reply_mac_q;
        reply_ip_d   = reply_ip_q;
        req_pend_d   = req_pend_q;
        if (load_reply_c) begin
            reply_pend_d = 1'b0;
        end
        if (i_trig_reply) begin
            reply_pend_d = 1'b1;
            reply_mac_d  = i_reply_mac;
            reply_ip_d   = i_reply_ip;
        end
        if (load_req_c) begin
            req_pend_d = 1'b0;
        end
        if (i_active_req || retry_set_c) begin
            req_pend_d = 1'b1;
        end
    end

    // Retry timer: armed by a finished request frame; resolution always overrides expiry.
    always_comb begin
        tmr_arm_d   = tmr_arm_q;
        tmr_d       = tmr_q;
        retry_cnt_d = retry_cnt_q;
        retry_set_c = 1'b0;
        req_fail_d  = 1'b0;
        if (tmr_arm_q) begin
            if (tmr_q == TMR_END) begin
                tmr_arm_d = 1'b0;
                if (retry_cnt_q < RTY_MAX) begin
                    retry_set_c = 1'b1;
                    retry_cnt_d = retry_cnt_q + RTY_W'(1);
                end else begin
                    req_fail_d  = 1'b1;
                    retry_cnt_d = '0;
                end
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
        if (RETRY_EN && frame_done_c && frm_req_q) begin
            tmr_arm_d = 1'b1;
            tmr_d     = '0;
        end
        if (i_active_req) begin
            tmr_arm_d   = 1'b0;
            retry_cnt_d = '0;
            req_fail_d  = 1'b0;
        end
        if (i_resolved) begin
            tmr_arm_d   = 1'b0;
            retry_cnt_d = '0;
            retry_set_c = 1'b0;
            req_fail_d  = 1'b0;
        end
    end

    // Output byte mux from next-state values so data lines up with the registered valid.
    always_comb begin
        hdr_c = {16'h0001, 16'h0800, 8'h06, 8'h04,
                 (frm_req_d ? 16'h0001 : 16'h0002),
                 frm_sha_d, frm_spa_d, frm_tha_d, frm_tpa_d};
        hdr_idx_c   = HDR_IDX_W'(HDR_LEN - 1) - cnt_d[HDR_IDX_W-1:0];
        mac_valid_d = (state_d == ST_SEND);
        mac_data_d  = '0;
        mac_last_d  = 1'b0;
        if (mac_valid_d) begin
            if (cnt_d < CNT_W'(HDR_LEN)) begin
                mac_data_d = hdr_c[hdr_idx_c];
            end
            mac_last_d = (cnt_d == LAST_IDX);
        end
        busy_d = (state_d != ST_IDLE) || reply_pend_d || req_pend_d;
    end

    assign mac.mac_data  = mac_data_q;
    assign mac.mac_valid = mac_valid_q;
    assign mac.mac_last  = mac_last_q;
    assign o_busy        = busy_q;
    assign o_req_fail    = req_fail_q;

endmodule

// File: tb/tb_arp_tx_gen.sv
// Randomized bench for arp_tx_gen with a byte-list reference model and a frame scoreboard.
module tb_arp_tx_gen;

    localparam int unsigned FL = 46;
    localparam int unsigned RC = 100;
    localparam int unsigned RM = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dst_ip = '0;
    logic        dst_ip_valid = 1'b0;
    logic [31:0] src_ip = '0;
    logic        src_ip_valid = 1'b0;
    logic [47:0] src_mac = '0;
    logic        src_mac_valid = 1'b0;
    logic        trig_reply = 1'b0;
    logic [47:0] reply_mac = '0;
    logic [31:0] reply_ip = '0;
    logic        active_req = 1'b0;
    logic        resolved = 1'b0;
    logic        busy;
    logic        req_fail;

    arp_tx_gen_if mac_if ();

    arp_tx_gen #(
        .P_RETRY_CYCLES (RC),
        .P_RETRY_MAX    (RM)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_dst_ip        (dst_ip),
        .i_dst_ip_valid  (dst_ip_valid),
        .i_src_ip        (src_ip),
        .i_src_ip_valid  (src_ip_valid),
        .i_src_mac       (src_mac),
        .i_src_mac_valid (src_mac_valid),
        .i_trig_reply    (trig_reply),
        .i_reply_mac     (reply_mac),
        .i_reply_ip      (reply_ip),
        .i_active_req    (active_req),
        .i_resolved      (resolved),
        .mac             (mac_if),
        .o_busy          (busy),
        .o_req_fail      (req_fail)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model state and expected byte stream.
    logic [47:0] m_src_mac;
    logic [31:0] m_src_ip;
    logic [31:0] m_dst_ip;
    logic [7:0]  exp_bytes[$];

    task automatic model_reset();
        m_src_mac = 48'h0;
        m_src_ip  = 32'hC0A8_0A01;
        m_dst_ip  = 32'hC0A8_0A00;
    endtask

    task automatic push_be(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_bytes.push_back(8'(v >> (8 * i)));
    endtask

    task automatic push_frame(input bit is_req, input logic [47:0] tha, input logic [31:0] tpa);
        push_be(48'h0001_0800_0604, 6);
        push_be(is_req ? 48'd1 : 48'd2, 2);
        push_be(m_src_mac, 6);
        push_be(48'(m_src_ip), 4);
        push_be(tha, 6);
        push_be(48'(tpa), 4);
        for (int i = 28; i < int'(FL); i++) exp_bytes.push_back(8'h00);
    endtask

    task automatic push_req();
        push_frame(1'b1, 48'hFFFF_FFFF_FFFF, m_dst_ip);
    endtask

    // Monitor: collects completed frames, checks last flag position and stall hold.
    logic [7:0] cur_bytes[$];
    logic [7:0] cap_bytes[$];
    int         cap_first[$];
    int         cap_last[$];
    int         fail_cyc[$];
    int         cur_first = 0;
    bit         hold_v = 1'b0;
    logic [7:0] hold_d = '0;

    always @(negedge clk) begin
        if (rst) begin
            cur_bytes.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 64'(mac_if.mac_valid), 64'd1);
                chk("hold_data", 64'(mac_if.mac_data), 64'(hold_d));
            end
            hold_v = 1'b0;
            if (mac_if.mac_valid) begin
                if (mac_if.mac_ready) begin
                    if (cur_bytes.size() == 0) cur_first = cyc;
                    chk("last_flag", 64'(mac_if.mac_last), 64'(cur_bytes.size() == int'(FL) - 1));
                    cur_bytes.push_back(mac_if.mac_data);
                    if (mac_if.mac_last) begin
                        foreach (cur_bytes[i]) cap_bytes.push_back(cur_bytes[i]);
                        cap_first.push_back(cur_first);
                        cap_last.push_back(cyc);
                        cur_bytes.delete();
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_d = mac_if.mac_data;
                end
            end
            if (req_fail) fail_cyc.push_back(cyc);
        end
    end

    // Optional random backpressure.
    bit rnd_ready = 1'b0;
    initial begin
        mac_if.mac_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) mac_if.mac_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        cap_bytes.delete();
        cap_first.delete();
        cap_last.delete();
        fail_cyc.delete();
        exp_bytes.delete();
    endtask

    task automatic compare_frames(input string tag);
        int n;
        chk({tag, "_len"}, 64'(cap_bytes.size()), 64'(exp_bytes.size()));
        n = (cap_bytes.size() < exp_bytes.size()) ? cap_bytes.size() : exp_bytes.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), 64'(cap_bytes[i]), 64'(exp_bytes[i]));
        cap_bytes.delete();
        exp_bytes.delete();
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (cap_first.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_frames_seen"}, 64'(cap_first.size() >= n), 64'd1);
    endtask

    task automatic wait_bytes(input int n, input int budget, input string tag);
        int k = 0;
        while (cur_bytes.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_bytes_seen"}, 64'(cur_bytes.size() >= n), 64'd1);
    endtask

    task automatic pulse_req(output int trig_cyc);
        trig_cyc   = cyc;
        active_req = 1'b1;
        tick();
        active_req = 1'b0;
    endtask

    task automatic resolve_and_idle(input string tag);
        int k = 0;
        resolved = 1'b1;
        tick();
        resolved = 1'b0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic write_cfg(input logic [47:0] mac, input logic [31:0] sip, input logic [31:0] dip);
        src_mac = mac;  src_mac_valid = 1'b1;
        src_ip  = sip;  src_ip_valid  = 1'b1;
        dst_ip  = dip;  dst_ip_valid  = 1'b1;
        tick();
        src_mac_valid = 1'b0;
        src_ip_valid  = 1'b0;
        dst_ip_valid  = 1'b0;
        m_src_mac = mac;
        m_src_ip  = sip;
        m_dst_ip  = dip;
    endtask

    initial begin
        int t;
        #200_000_0;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [47:0] rmac;
        logic [31:0] rip;
        model_reset();

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_data", 64'(mac_if.mac_data), 64'd0);
        chk("rst_valid", 64'(mac_if.mac_valid), 64'd0);
        chk("rst_last", 64'(mac_if.mac_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fail", 64'(req_fail), 64'd0);
        rst = 1'b0;
        tick();

        // Single request with default configuration
        clear_sb();
        push_req();
        pulse_req(t);
        chk("req_busy", 64'(busy), 64'd1);
        wait_frames(1, 200, "single");
        if (cap_first.size() >= 1) begin
            chk("single_latency", 64'(cap_first[0]), 64'(t + 3));
            chk("single_span", 64'(cap_last[0] - cap_first[0]), 64'(FL - 1));
        end
        compare_frames("single");
        resolve_and_idle("single");

        // Reply and request in the same cycle
        clear_sb();
        push_frame(1'b0, 48'h1122_3344_5566, 32'hC0A8_0A05);
        push_req();
        reply_mac  = 48'h1122_3344_5566;
        reply_ip   = 32'hC0A8_0A05;
        trig_reply = 1'b1;
        active_req = 1'b1;
        tick();
        trig_reply = 1'b0;
        active_req = 1'b0;
        wait_frames(2, 400, "both");
        if (cap_first.size() >= 2)
            chk("both_gap", 64'(cap_first[1] - cap_last[0]), 64'd3);
        compare_frames("both");
        resolve_and_idle("both");

        // Backpressure at byte 10 with a new local MAC
        clear_sb();
        write_cfg(48'h02AB_CDEF_1234, 32'hC0A8_0A01, 32'hC0A8_0A00);
        push_req();
        pulse_req(t);
        wait_bytes(10, 200, "bp");
        mac_if.mac_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_data", 64'(mac_if.mac_data), 64'(m_src_mac[31:24]));
            tick();
        end
        mac_if.mac_ready = 1'b1;
        wait_frames(1, 200, "bp");
        compare_frames("bp");
        resolve_and_idle("bp");

        // Configuration write mid-frame does not affect the current frame
        clear_sb();
        push_req();
        pulse_req(t);
        wait_bytes(20, 200, "midcfg");
        src_ip = 32'hC0A8_0A63;
        src_ip_valid = 1'b1;
        tick();
        src_ip_valid = 1'b0;
        m_src_ip = 32'hC0A8_0A63;
        wait_frames(1, 200, "midcfg");
        push_req();
        pulse_req(t);
        wait_frames(2, 200, "midcfg2");
        compare_frames("midcfg");
        resolve_and_idle("midcfg");

        // Retries run out and flag failure
        clear_sb();
        push_req();
        push_req();
        push_req();
        pulse_req(t);
        wait_frames(3, 1000, "retry");
        repeat (RC + 60) tick();
        chk("retry_nframes", 64'(cap_first.size()), 64'd3);
        chk("retry_nfail", 64'(fail_cyc.size()), 64'd1);
        if (cap_first.size() >= 3) begin
            chk("retry_gap1", 64'(cap_first[1] - cap_last[0]), 64'(RC + 3));
            chk("retry_gap2", 64'(cap_first[2] - cap_last[1]), 64'(RC + 3));
            if (fail_cyc.size() >= 1)
                chk("retry_fail_at", 64'(fail_cyc[0] - cap_last[2]), 64'(RC + 1));
        end
        compare_frames("retry");
        chk("retry_idle", 64'(busy), 64'd0);

        // Resolution after the first frame stops retries
        clear_sb();
        push_req();
        pulse_req(t);
        wait_frames(1, 200, "resolved");
        repeat (5) tick();
        resolved = 1'b1;
        tick();
        resolved = 1'b0;
        repeat (RC + 60) tick();
        chk("resolved_nframes", 64'(cap_first.size()), 64'd1);
        chk("resolved_nfail", 64'(fail_cyc.size()), 64'd0);
        compare_frames("resolved");

        // Randomized triggers, merges, configuration and backpressure
        for (int it = 0; it < 10; it++) begin
            bit do_reply, do_req, do_merge;
            clear_sb();
            if ($urandom_range(0, 1) == 1)
                write_cfg(48'({$urandom(), $urandom()}), $urandom(), $urandom());
            case ($urandom_range(0, 2))
                0:       begin do_reply = 1'b1; do_req = 1'b0; end
                1:       begin do_reply = 1'b0; do_req = 1'b1; end
                default: begin do_reply = 1'b1; do_req = 1'b1; end
            endcase
            do_merge  = do_reply && ($urandom_range(0, 1) == 1);
            rnd_ready = 1'b1;
            rmac = 48'({$urandom(), $urandom()});
            rip  = $urandom();
            trig_reply = do_reply;
            reply_mac  = rmac;
            reply_ip   = rip;
            active_req = do_req;
            tick();
            trig_reply = 1'b0;
            active_req = 1'b0;
            if (do_merge) begin
                rmac = 48'({$urandom(), $urandom()});
                rip  = $urandom();
                trig_reply = 1'b1;
                reply_mac  = rmac;
                reply_ip   = rip;
                tick();
                trig_reply = 1'b0;
            end
            if (do_reply) push_frame(1'b0, rmac, rip);
            if (do_req) push_req();
            wait_frames(int'(do_reply) + int'(do_req), 1500, $sformatf("rnd%0d", it));
            rnd_ready = 1'b0;
            mac_if.mac_ready = 1'b1;
            chk($sformatf("rnd%0d_count", it), 64'(cap_first.size()), 64'(int'(do_reply) + int'(do_req)));
            compare_frames($sformatf("rnd%0d", it));
            resolve_and_idle($sformatf("rnd%0d", it));
        end

        // Reset in the middle of a frame
        clear_sb();
        pulse_req(t);
        wait_bytes(15, 200, "midrst");
        rst = 1'b1;
        tick();
        chk("midrst_data", 64'(mac_if.mac_data), 64'd0);
        chk("midrst_valid", 64'(mac_if.mac_valid), 64'd0);
        chk("midrst_last", 64'(mac_if.mac_last), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        model_reset();
        tick();
        chk("midrst_nframes", 64'(cap_first.size()), 64'd0);
        push_req();
        pulse_req(t);
        wait_frames(1, 200, "postrst");
        if (cap_first.size() >= 1)
            chk("postrst_latency", 64'(cap_first[0]), 64'(t + 3));
        compare_frames("postrst");
        resolve_and_idle("postrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
